mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between EX/MEM and the data bus (IDLE/REQ/WAIT/DONE).
// Latency: non-memory ops pass through with zero added latency; store >= 3 cycles, load >= 4.
// Backpressure: stall held high until DONE while the bus withholds gnt/rvalid.
// Optional: define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exmem_reg_wdata_i,
  input  logic [4:0]  exmem_reg_waddr_i,
  input  logic        exmem_reg_we_i,
  input  logic        exmem_mtype_i,
  input  logic        exmem_mem_rw_i,
  input  logic [1:0]  exmem_mem_width_i,
  input  logic [31:0] exmem_mem_addr_i,
  input  logic        exmem_mem_rdtype_i,
  input  logic        exmem_ins_flag_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic        mem_ins_flag_o,
  output logic        mem_stall_req_o,
  output logic        mem_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] load_buf;
  logic [1:0]  off;
  logic        misalign;
  logic [31:0] rshift;
  logic [31:0] load_ext;

  assign off = exmem_mem_addr_i[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = exmem_mtype_i && (state == IDLE) &&
                    (((exmem_mem_width_i == 2'b01) && off[0]) ||
                     (exmem_mem_width_i[1] && (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Bus address/data/lane enables come straight from the EX/MEM register,
  // which stays frozen while we stall, so they are stable until grant.
  always_comb begin
    dbus_addr_o = {exmem_mem_addr_i[31:2], 2'b00};
    dbus_we_o   = exmem_mem_rw_i;
    case (exmem_mem_width_i)
      2'b00: begin
        dbus_wdata_o = {4{exmem_reg_wdata_i[7:0]}};
        dbus_be_o    = 4'b0001 << off;
      end
      2'b01: begin
        dbus_wdata_o = {2{exmem_reg_wdata_i[15:0]}};
        dbus_be_o    = 4'b0011 << off;
      end
      default: begin
        dbus_wdata_o = exmem_reg_wdata_i;
        dbus_be_o    = 4'b1111;
      end
    endcase
  end

  // Load extract: shift the addressed lane to bit 0, then size and extend.
  always_comb begin
    rshift = dbus_rdata_i >> {off, 3'b000};
    case (exmem_mem_width_i)
      2'b00:   load_ext = exmem_mem_rdtype_i ? {24'd0, rshift[7:0]}
                                             : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = exmem_mem_rdtype_i ? {16'd0, rshift[15:0]}
                                             : {{16{rshift[15]}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  // FSM state and load buffer; gnt/rvalid only observed in REQ/WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: if (exmem_mtype_i && !misalign) state <= REQ;
        REQ:  if (dbus_gnt_i) state <= exmem_mem_rw_i ? DONE : WAIT;
        WAIT: if (dbus_rvalid_i) begin
                load_buf <= load_ext;
                state    <= DONE;
              end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback/stall decode. During reset behave as IDLE with stall/req/misalign forced low.
  always_comb begin
    dbus_req_o      = 1'b0;
    mem_stall_req_o = 1'b0;
    mem_misalign_o  = 1'b0;
    mem_reg_wdata_o = exmem_reg_wdata_i;
    mem_reg_waddr_o = exmem_reg_waddr_i;
    mem_reg_we_o    = 1'b0;
    mem_ins_flag_o  = 1'b0;
    if (rst) begin
      mem_reg_we_o   = exmem_reg_we_i & ~exmem_mtype_i;
      mem_ins_flag_o = exmem_ins_flag_i & ~exmem_mtype_i;
    end else begin
      case (state)
        IDLE: begin
          if (!exmem_mtype_i) begin
            mem_reg_we_o   = exmem_reg_we_i;
            mem_ins_flag_o = exmem_ins_flag_i;
          end else if (misalign) begin
            mem_misalign_o = 1'b1;
          end else begin
            mem_stall_req_o = 1'b1;
          end
        end
        REQ: begin
          dbus_req_o      = 1'b1;
          mem_stall_req_o = 1'b1;
        end
        WAIT: mem_stall_req_o = 1'b1;
        default: begin
          mem_ins_flag_o = exmem_ins_flag_i;
          if (!exmem_mem_rw_i) begin
            mem_reg_wdata_o = load_buf;
            mem_reg_we_o    = exmem_reg_we_i;
          end
        end
      endcase
    end
  end

endmodule
